decoder_op_x1_00xxx001_seq: RTL
===============================

DECODER_OP_X1_00XXX001_SEQ -- requirements
Module: decoder_op_x1_00xxx001_seq

Interface
REQ-001 SHALL have parameter REG_W, default 16, register-pair width in bits; must be a multiple of 8 and of ALU_W.
REQ-002 SHALL have parameter ALU_W, default 8, adder slice width per cycle.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are named Clock and Reset.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 Reset  input  1  asynchronous active-high reset.
REQ-006 Start  input  1  opcode valid; sampled only when Busy=0.
REQ-007 Source  input  8  opcode byte.
REQ-008 Abort  input  1  synchronous cancel of the current operation.
REQ-009 MemAck  input  1  read data valid this cycle.
REQ-010 MemData  input  8  operand byte.
REQ-011 HL_in, SS_in  input  REG_W  HL value and the selected source pair value.
REQ-012 Busy  output  1  operation in progress.
REQ-013 XPT  output  5  step counter.
REQ-014 MemRead  output  1  operand read request.
REQ-015 SS_Sel  output  2  source/destination pair select (0=BC, 1=DE, 2=HL, 3=SP) = Source[5:4], latched at Start.
REQ-016 RegWrite  output  1  one-cycle write strobe.
REQ-017 RegSel  output  2  write pair select.
REQ-018 WriteData  output  REG_W  write value.
REQ-019 FlagWrite  output  1  flag write strobe.
REQ-020 FlagC, FlagH, FlagN  output  1 each  flag values.
REQ-021 Done  output  1  completion pulse.
REQ-022 Illegal  output  1  unsupported-opcode pulse.

Function
REQ-023 SHALL implement states IDLE, FETCH, ALU and WRITE.
REQ-024 In IDLE, Start=1 with Source matching 00xx0001 (LD dd,nn) SHALL latch the opcode and enter FETCH; 00xx1001 (ADD HL,ss) SHALL enter ALU; any other value SHALL pulse Illegal for one cycle and remain in IDLE.
REQ-025 FETCH SHALL hold MemRead=1 until MemAck=1.
REQ-026 Each MemAck SHALL capture MemData into byte k, low byte first (k=0..REG_W/8-1).
REQ-027 After the last byte is captured, the block SHALL enter WRITE on the next cycle.
REQ-028 ALU SHALL add one ALU_W slice of HL_in+SS_in per cycle, LSB slice first, carrying between slices; it SHALL take REG_W/ALU_W cycles, then enter WRITE.
REQ-029 In WRITE, RegWrite=1 and Done=1 SHALL be asserted for exactly one cycle, and the block SHALL then return to IDLE.
REQ-030 For LD, WRITE SHALL drive RegSel=SS_Sel, WriteData=captured bytes and FlagWrite=0.
REQ-031 For ADD, WRITE SHALL drive RegSel=2, WriteData=sum mod 2^REG_W and FlagWrite=1.
REQ-032 ADD flags: FlagC=carry out of bit REG_W-1, FlagH=carry out of bit REG_W-5, FlagN=0.
REQ-033 XPT SHALL be 0 in IDLE, increment each Busy cycle, and saturate at 31.
REQ-034 Busy SHALL be 1 in FETCH, ALU and WRITE.
REQ-035 Start while Busy SHALL be ignored.
REQ-036 Latency with defaults: ADD Start at cycle 0 gives WRITE at cycle 3; LD with MemAck every cycle gives WRITE at cycle 3.
REQ-037 Abort=1 in FETCH or ALU SHALL return the block to IDLE next cycle with no RegWrite, FlagWrite or Done.
REQ-038 Abort SHALL win over a simultaneous MemAck.
REQ-039 Abort in WRITE SHALL be ignored, and the write SHALL complete.
REQ-040 MemAck outside FETCH SHALL be ignored.

Reset
REQ-041 On Reset=1, the block SHALL enter IDLE and all outputs, the byte index, the carry and the latched opcode SHALL be 0, asynchronously.
REQ-042 Reset mid-operation SHALL discard partial results, and no write SHALL occur after release.

Verification
REQ-043 ADD HL,BC (0x09), HL_in=0x0FFF, SS_in=0x0001 -> cycle 3: WriteData=0x1000, RegSel=2, FlagH=1, FlagC=0, FlagN=0, Done=1.
REQ-044 ADD HL,SP (0x39), HL_in=0xFFFF, SS_in=0x0001 -> WriteData=0x0000, FlagC=1, FlagH=1.
REQ-045 LD DE,nn (0x11), MemAck delayed 2 cycles per byte, bytes 0x34 then 0x12 -> MemRead held while waiting; RegSel=1, WriteData=0x1234, FlagWrite=0.
REQ-046 LD BC,nn: Abort asserted together with the first MemAck -> IDLE next cycle, no RegWrite; a new Start is accepted afterwards.
REQ-047 Start with Source=0x00 -> Illegal=1 for one cycle, Busy stays 0.
REQ-048 Reset asserted during ALU cycle 1 -> all outputs 0 immediately, no Done after release.
REQ-049 Parameter run REG_W=32, ALU_W=8: ADD 0x0000FFFF+0x00000001 -> 0x00010000 after 4 ALU cycles, FlagH=0, FlagC=0.

Source files
------------

// File: rtl/decoder_op_x1_00xxx001_seq.sv
// Sequencer for LD dd,nn (00dd0001) and ADD HL,ss (00ss1001).
// LD operands arrive byte-serially over MemRead/MemAck; ADD runs one ALU_W slice per cycle.
//
//  state | meaning
//  IDLE  | waiting for Start, XPT held at 0
//  FETCH | requesting operand bytes, low byte first
//  ALU   | adding one slice of HL_in+SS_in per cycle
//  WRITE | one-cycle register/flag write with Done
module decoder_op_x1_00xxx001_seq #(
    parameter int REG_W = 16,
    parameter int ALU_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [7:0]       Source,
    input  logic             Abort,
    input  logic             MemAck,
    input  logic [7:0]       MemData,
    input  logic [REG_W-1:0] HL_in,
    input  logic [REG_W-1:0] SS_in,
    output logic             Busy,
    output logic [4:0]       XPT,
    output logic             MemRead,
    output logic [1:0]       SS_Sel,
    output logic             RegWrite,
    output logic [1:0]       RegSel,
    output logic [REG_W-1:0] WriteData,
    output logic             FlagWrite,
    output logic             FlagC,
    output logic             FlagH,
    output logic             FlagN,
    output logic             Done,
    output logic             Illegal
);

    localparam int N_BYTES = REG_W / 8;
    localparam int N_SLICE = REG_W / ALU_W;
    localparam int N_MAX   = (N_BYTES > N_SLICE) ? N_BYTES : N_SLICE;
    localparam int CNT_W   = $clog2(N_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICE - 1);
    // Half carry is the carry out of bit REG_W-5, i.e. the carry into bit REG_W-4.
    localparam int H_BIT = REG_W - 4;
    localparam logic [CNT_W-1:0] H_SLICE = CNT_W'(H_BIT / ALU_W);
    localparam int H_LOC = H_BIT % ALU_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ALU   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             half_q;
    logic             op_add_q;
    logic [1:0]       ss_sel_q;
    logic [REG_W-1:0] res_q;
    logic [4:0]       xpt_q;
    logic             illegal_q;

    logic             is_ld, is_add;
    logic [31:0]      slice_sh, byte_sh;
    logic [ALU_W-1:0] slice_a, slice_b, slice_s;
    logic [ALU_W:0]   sum_w;
    logic             half_n;

    always_comb begin
        is_ld    = (Source[7:6] == 2'b00) && (Source[3:0] == 4'b0001);
        is_add   = (Source[7:6] == 2'b00) && (Source[3:0] == 4'b1001);
        slice_sh = 32'(cnt_q) * 32'(ALU_W);
        byte_sh  = 32'(cnt_q) * 32'd8;
        slice_a  = ALU_W'(HL_in >> slice_sh);
        slice_b  = ALU_W'(SS_in >> slice_sh);
        sum_w    = {1'b0, slice_a} + {1'b0, slice_b} + (ALU_W+1)'(carry_q);
        slice_s  = sum_w[ALU_W-1:0];
        half_n   = slice_a[H_LOC] ^ slice_b[H_LOC] ^ slice_s[H_LOC];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start && is_ld)
                    state_nxt = FETCH;
                else if (Start && is_add)
                    state_nxt = ALU;
            end
            FETCH: begin
                if (Abort)
                    state_nxt = IDLE;
                else if (MemAck && (cnt_q == LAST_BYTE))
                    state_nxt = WRITE;
            end
            ALU: begin
                if (Abort)
                    state_nxt = IDLE;
                else if (cnt_q == LAST_SLICE)
                    state_nxt = WRITE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            half_q    <= 1'b0;
            op_add_q  <= 1'b0;
            ss_sel_q  <= 2'd0;
            res_q     <= '0;
            xpt_q     <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_q <= (state == IDLE) && Start && !is_ld && !is_add;

            if (state_nxt == IDLE)
                xpt_q <= 5'd0;
            else if (xpt_q != 5'd31)
                xpt_q <= xpt_q + 5'd1;

            // Any return to IDLE (done, abort) drops partial results.
            if (state_nxt == IDLE) begin
                cnt_q   <= '0;
                carry_q <= 1'b0;
                half_q  <= 1'b0;
                res_q   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        op_add_q <= Source[3];
                        ss_sel_q <= Source[5:4];
                        cnt_q    <= '0;
                        carry_q  <= 1'b0;
                        half_q   <= 1'b0;
                        res_q    <= '0;
                    end
                    FETCH: begin
                        if (MemAck) begin
                            res_q <= res_q | (REG_W'(MemData) << byte_sh);
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ALU: begin
                        res_q   <= res_q | (REG_W'(slice_s) << slice_sh);
                        carry_q <= sum_w[ALU_W];
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == H_SLICE)
                            half_q <= half_n;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Busy      = (state != IDLE);
    assign MemRead   = (state == FETCH);
    assign RegWrite  = (state == WRITE);
    assign Done      = (state == WRITE);
    assign XPT       = xpt_q;
    assign SS_Sel    = ss_sel_q;
    assign Illegal   = illegal_q;
    assign RegSel    = (state != WRITE) ? 2'd0 : (op_add_q ? 2'd2 : ss_sel_q);
    assign WriteData = (state == WRITE) ? res_q : '0;
    assign FlagWrite = (state == WRITE) && op_add_q;
    assign FlagC     = (state == WRITE) && op_add_q && carry_q;
    assign FlagH     = (state == WRITE) && op_add_q && half_q;
    assign FlagN     = 1'b0;

endmodule
